// File: rtl/regfile_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump_pkg
// Brief    : Shared CPU-side definitions for the register-file dump engine:
//            default data width and the dump FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_dump_pkg;

  // Default architectural data word width.
  localparam int XLEN_DEF = 32;

  // Dump sequencer states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_SEND  = 2'd2,
    S_DONE  = 2'd3
  } dump_state_e;

endpackage : regfile_dump_pkg
`default_nettype wire

// File: rtl/regfile_dump.sv
`default_nettype none
// ============================================================================
// Module   : regfile_dump
// Brief    : Streams x0..x(NREGS-1) followed by a snapshot of the PC over a
//            valid/ready interface. Each word takes a FETCH cycle (read the
//            register file) and at least one SEND cycle (hold until accepted).
// Revision : 1.0 - initial release
// ============================================================================
module regfile_dump
  import regfile_dump_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] pc_i,
  output logic [4:0]      rf_addr,
  input  logic [XLEN-1:0] rf_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [5:0]      out_idx,
  output logic            out_last,
  output logic            busy,
  output logic            done
);

  // Index of the trailing PC word; also the ceiling for idx.
  localparam logic [5:0] LAST_IDX = 6'(NREGS);

  dump_state_e     state;
  dump_state_e     state_next;
  logic [5:0]      idx;
  logic [XLEN-1:0] pc_snap;

  // The register file is addressed straight from the word counter.
  assign rf_addr = idx[4:0];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one FETCH/SEND pair per word, then a single DONE cycle.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_FETCH;
      S_FETCH: state_next = S_SEND;
      S_SEND: begin
        if (out_ready) begin
          state_next = (idx == LAST_IDX) ? S_DONE : S_FETCH;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // Datapath: PC snapshot, word counter and the held output word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      pc_snap   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pc_snap <= pc_i;
            idx     <= '0;
          end
        end
        S_FETCH: begin
          // x0 is hardwired zero; the final slot carries the PC snapshot.
          if (idx == 6'd0) begin
            out_data <= '0;
          end else if (idx == LAST_IDX) begin
            out_data <= pc_snap;
          end else begin
            out_data <= rf_rdata;
          end
          out_idx   <= idx;
          out_last  <= (idx == LAST_IDX);
          out_valid <= 1'b1;
        end
        S_SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (idx != LAST_IDX) begin
              idx <= idx + 6'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule : regfile_dump
`default_nettype wire

// File: tb/tb_regfile_dump.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_dump
// Brief    : Randomized scoreboard bench for regfile_dump. Stimulus pushes
//            the expected word stream of each dump; a monitor pops and
//            compares every accepted word and checks hold stability and the
//            done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_dump;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] pc_i;
  logic [4:0]  rf_addr;
  logic [31:0] rf_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_idx;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [31:0] rf [32];
  assign rf_rdata = rf[rf_addr];

  typedef struct packed {
    logic [31:0] data;
    logic [5:0]  idx;
    logic        last;
  } word_t;

  word_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;
  int stall_cnt = 0;

  bit          mon_en = 1'b0;
  bit          prev_hold = 1'b0;
  bit          prev_last_acc = 1'b0;
  logic [31:0] prev_data;
  logic [5:0]  prev_idx;
  logic        prev_lastv;

  regfile_dump #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .rst(rst), .start(start), .pc_i(pc_i),
    .rf_addr(rf_addr), .rf_rdata(rf_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference model: a dump is the architectural registers in order with x0
  // reading as zero, followed by the PC captured at start.
  task automatic push_dump(input logic [31:0] pc);
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back('{data: (i == 0) ? 32'h0 : rf[i], idx: 6'(i), last: 1'b0});
    end
    exp_q.push_back('{data: pc, idx: 6'd32, last: 1'b1});
  endtask

  task automatic randomize_rf();
    rf[0] = 32'hDEADBEEF;
    for (int i = 1; i < 32; i++) rf[i] = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("wait_idle_timeout", 1, 0);
  endtask

  // Issue a one-cycle start; pc_i is disturbed right after it is sampled.
  task automatic begin_dump(input logic [31:0] pc, input bit rnd);
    wait_idle();
    if (rnd) randomize_rf();
    push_dump(pc);
    pc_i  = pc;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    pc_i  = pc ^ 32'h0000_0300;
  endtask

  task automatic do_dump(input logic [31:0] pc, input bit rnd, input bit check_cycles);
    int n;
    begin_dump(pc, rnd);
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    chk("valid_latency_1", out_valid, 0);
    @(negedge clk);
    chk("valid_latency_2", out_valid, 1);
    n = 2;
    while (!done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
    else if (check_cycles) chk("start_to_done_cycles", n, 67);
  endtask

  // Ready driver: always-ready, random backpressure, or a 5-cycle stall on x7.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (out_valid && out_idx == 6'd7 && stall_cnt < 5) begin
            out_ready = 1'b0;
            stall_cnt++;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor: stability while stalled, word comparison on acceptance,
  // and a done pulse exactly one cycle after the last word is taken.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        chk("done_pulse", done, prev_last_acc);
        if (prev_hold) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, prev_data);
          chk("hold_idx", out_idx, prev_idx);
          chk("hold_last", out_last, prev_lastv);
        end
        if (out_valid) chk("rf_addr_tracks_idx", rf_addr, out_idx[4:0]);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_word_idx", out_idx, 6'h3F);
          end else begin
            word_t w;
            w = exp_q.pop_front();
            chk("word_data", out_data, w.data);
            chk("word_idx", out_idx, w.idx);
            chk("word_last", out_last, w.last);
          end
          prev_last_acc = out_last;
        end else begin
          prev_last_acc = 1'b0;
        end
        prev_hold  = out_valid && !out_ready;
        prev_data  = out_data;
        prev_idx   = out_idx;
        prev_lastv = out_last;
      end
    end
  end

  initial begin
    int n;
    int dones;
    logic [31:0] p;
    rst   = 1'b1;
    start = 1'b0;
    pc_i  = 32'h0;
    for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h11;
    rf[0] = 32'hDEADBEEF;

    // Reset state.
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_idx", out_idx, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rf_addr", rf_addr, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Known register pattern, always ready, PC 0x100 then disturbed to 0x200.
    ready_mode = 0;
    do_dump(32'h100, 1'b0, 1'b1);

    // 5-cycle stall on word 7.
    ready_mode = 2;
    stall_cnt  = 0;
    do_dump($urandom, 1'b1, 1'b0);
    chk("stall_cycles", stall_cnt, 5);

    // Random backpressure.
    ready_mode = 1;
    repeat (4) do_dump($urandom, 1'b1, 1'b0);

    // Asynchronous reset in the middle of word 12.
    begin_dump($urandom, 1'b1);
    n = 0;
    @(negedge clk);
    while (!(out_valid && out_idx == 6'd12) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_idx12", out_idx, 12);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_data", out_data, 0);
    chk("abort_idx", out_idx, 0);
    chk("abort_last", out_last, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rf_addr", rf_addr, 0);
    exp_q.delete();
    prev_hold     = 1'b0;
    prev_last_acc = 1'b0;
    #1;
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("post_abort_quiet", {out_valid, busy, done}, 3'b000);
    end
    do_dump($urandom, 1'b1, 1'b0);

    // start held high: two back-to-back dumps, each with one done pulse.
    wait_idle();
    randomize_rf();
    p = $urandom;
    pc_i = p;
    push_dump(p);
    push_dump(p);
    start = 1'b1;
    dones = 0;
    n = 0;
    while (dones < 2 && n < 3000) begin
      @(negedge clk);
      n++;
      if (done) dones++;
    end
    start = 1'b0;
    chk("held_start_dones", dones, 2);
    repeat (4) begin
      @(negedge clk);
      chk("held_start_stops", {out_valid, busy}, 2'b00);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_regfile_dump
`default_nettype wire
